// File: rtl/clk_div_pkg.sv
// Shared constants, channel state type and index-width helper for the
// clock-divider bank.
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } ch_state_e;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration and output bundle of the clock-divider bank.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = CNT_W_DEFAULT
);
  localparam int CH_W = ch_width(NCH);

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic             sync;
  logic [NCH-1:0]   outclk;
  logic [NCH-1:0]   rise_stb;
  logic [NCH-1:0]   fall_stb;
  logic [NCH-1:0]   running;

  modport master (
    output cfg_wr, cfg_ch, cfg_half, sync,
    input  outclk, rise_stb, fall_stb, running
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_half, sync,
    output outclk, rise_stb, fall_stb, running
  );
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: active/shadow half-period, half-period counter,
// registered square wave and single-cycle edge strobes.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
  input  logic             sync,
  output logic             outclk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running
);

  logic [CNT_W-1:0] act_reg;
  logic [CNT_W-1:0] shadow_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pending_reg;
  logic             outclk_reg;
  logic             rise_reg;
  logic             fall_reg;

  ch_state_e        state;
  logic             at_terminal;
  logic [CNT_W-1:0] act_next;

  assign state       = (act_reg != '0) ? RUNNING : STOPPED;
  assign at_terminal = (count_reg == act_reg - CNT_W'(1));
  // A write landing on a boundary or sync edge bypasses the shadow.
  assign act_next    = wr ? wdata : (pending_reg ? shadow_reg : act_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_reg     <= '0;
      shadow_reg  <= '0;
      count_reg   <= '0;
      pending_reg <= 1'b0;
      outclk_reg  <= 1'b0;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (state == STOPPED) begin
        if (wr) begin
          act_reg   <= wdata;
          count_reg <= '0;
        end
      end else if (sync) begin
        count_reg   <= '0;
        outclk_reg  <= 1'b0;
        fall_reg    <= outclk_reg;
        act_reg     <= act_next;
        pending_reg <= 1'b0;
      end else if (at_terminal) begin
        count_reg  <= '0;
        outclk_reg <= ~outclk_reg;
        if (outclk_reg) begin
          // Falling edge is the full-period boundary.
          fall_reg    <= 1'b1;
          act_reg     <= act_next;
          pending_reg <= 1'b0;
        end else begin
          rise_reg <= 1'b1;
          if (wr) begin
            shadow_reg  <= wdata;
            pending_reg <= 1'b1;
          end
        end
      end else begin
        count_reg <= count_reg + CNT_W'(1);
        if (wr) begin
          shadow_reg  <= wdata;
          pending_reg <= 1'b1;
        end
      end
    end
  end

  assign outclk   = outclk_reg;
  assign rise_stb = rise_reg;
  assign fall_stb = fall_reg;
  assign running  = (state == RUNNING);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock-pattern channels sharing one config port
// and one phase-align pulse.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  clk_div_bank_if.slave bus
);

  localparam int CH_W = ch_width(NCH);

  logic [NCH-1:0] wr_en;
  logic [NCH-1:0] outclk_vec;
  logic [NCH-1:0] rise_vec;
  logic [NCH-1:0] fall_vec;
  logic [NCH-1:0] run_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      // Selects at or beyond NCH match no channel and are dropped.
      assign wr_en[gi] = bus.cfg_wr && (bus.cfg_ch == CH_W'(gi));

      clk_div_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr       (wr_en[gi]),
        .wdata    (bus.cfg_half),
        .sync     (bus.sync),
        .outclk   (outclk_vec[gi]),
        .rise_stb (rise_vec[gi]),
        .fall_stb (fall_vec[gi]),
        .running  (run_vec[gi])
      );
    end
  endgenerate

  assign bus.outclk   = outclk_vec;
  assign bus.rise_stb = rise_vec;
  assign bus.fall_stb = fall_vec;
  assign bus.running  = run_vec;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized and directed check of clk_div_bank against a phase-position
// reference model.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NCH   = 5;
  localparam int CNT_W = 32;
  localparam int CH_W  = ch_width(NCH);

  logic clk;
  logic reset_n;

  clk_div_bank_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each running channel tracks its position t within the current
  // period (0 .. 2*act-1); the output is high for the second half.
  longint        m_act[NCH];
  longint        m_shadow[NCH];
  bit            m_pend[NCH];
  longint        m_t[NCH];
  logic [NCH-1:0] exp_out, exp_rise, exp_fall, exp_run;

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 0; m_shadow[i] = 0; m_pend[i] = 0; m_t[i] = 0;
    end
    exp_out = '0; exp_rise = '0; exp_fall = '0; exp_run = '0;
  endtask

  task automatic model_edge(input bit wr, input int ch, input longint half, input bit sy);
    for (int i = 0; i < NCH; i++) begin
      bit     wi;
      bit     old_o, new_o;
      longint applied;
      wi      = wr && (ch == i);
      old_o   = exp_out[i];
      applied = wi ? half : (m_pend[i] ? m_shadow[i] : m_act[i]);
      if (m_act[i] == 0) begin
        if (wi) begin
          m_act[i] = half;
          m_t[i]   = 0;
        end
      end else if (sy) begin
        m_act[i] = applied; m_pend[i] = 0; m_t[i] = 0;
      end else begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == 2 * m_act[i]) begin
          m_act[i] = applied; m_pend[i] = 0; m_t[i] = 0;
        end else if (wi) begin
          m_shadow[i] = half; m_pend[i] = 1;
        end
      end
      new_o       = (m_act[i] != 0) && (m_t[i] >= m_act[i]);
      exp_out[i]  = new_o;
      exp_rise[i] = new_o & ~old_o;
      exp_fall[i] = old_o & ~new_o;
      exp_run[i]  = (m_act[i] != 0);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".outclk"},   16'(bus.outclk),   16'(exp_out));
    chk({tag, ".rise_stb"}, 16'(bus.rise_stb), 16'(exp_rise));
    chk({tag, ".fall_stb"}, 16'(bus.fall_stb), 16'(exp_fall));
    chk({tag, ".running"},  16'(bus.running),  16'(exp_run));
  endtask

  task automatic step(input bit wr, input int ch, input longint half, input bit sy, input string tag);
    bus.cfg_wr   = wr;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_half = CNT_W'(half);
    bus.sync     = sy;
    @(posedge clk);
    model_edge(wr, ch, half, sy);
    #1;
    chk_all(tag);
    bus.cfg_wr = 1'b0;
    bus.sync   = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, tag);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.cfg_wr   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_half = '0;
    bus.sync     = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    #3 reset_n = 1'b1;

    // ch0 H=3: rise at E0+3, fall at E0+6
    step(1, 0, 3, 0, "ch0_wr3");
    chk("ch0_running", 16'(bus.running[0]), 16'd1);
    idle(2, "ch0_low");
    chk("ch0_low_before_rise", 16'(bus.outclk[0]), 16'd0);
    step(0, 0, 0, 0, "ch0_e3");
    chk("ch0_rise_at_E0+3", 16'(bus.rise_stb[0]), 16'd1);
    idle(2, "ch0_high");
    step(0, 0, 0, 0, "ch0_e6");
    chk("ch0_fall_at_E0+6", 16'(bus.fall_stb[0]), 16'd1);

    // ch1 H=4, reprogram to 2 during the high phase
    step(1, 1, 4, 0, "ch1_wr4");
    idle(5, "ch1_run");
    chk("ch1_high_before_rewrite", 16'(bus.outclk[1]), 16'd1);
    step(1, 1, 2, 0, "ch1_wr2");
    idle(14, "ch1_shadow");

    // ch2 H=1: toggles every cycle
    step(1, 2, 1, 0, "ch2_wr1");
    idle(6, "ch2_fast");

    // ch3 H=5 then stop
    step(1, 3, 5, 0, "ch3_wr5");
    idle(7, "ch3_run");
    step(1, 3, 0, 0, "ch3_wr0");
    idle(12, "ch3_stop");
    chk("ch3_stopped", 16'(bus.running[3]), 16'd0);

    // ch1 to H=5, then phase-align
    step(1, 1, 5, 0, "ch1_wr5");
    idle(13, "pre_sync");
    step(0, 0, 0, 1, "sync");
    chk("sync_ch0_low", 16'(bus.outclk[0]), 16'd0);
    chk("sync_ch1_low", 16'(bus.outclk[1]), 16'd0);
    idle(6, "post_sync");

    // out-of-range channel selects are dropped
    step(1, 5, 7, 0, "wr_ch5");
    step(1, 7, 7, 0, "wr_ch7");
    idle(3, "post_bad_ch");

    // random writes, syncs, stops and same-edge combinations
    for (int n = 0; n < 500; n++) begin
      bit     wr, sy;
      int     ch;
      longint half;
      wr   = ($urandom_range(0, 3) == 0);
      ch   = $urandom_range(0, 7);
      half = $urandom_range(0, 6);
      sy   = ($urandom_range(0, 29) == 0);
      step(wr, ch, half, sy, "rand");
    end

    // keep several channels running, then async reset mid-period
    step(1, 0, 4, 0, "pre_rst0");
    step(1, 1, 3, 0, "pre_rst1");
    idle(5, "pre_rst");
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_all("in_reset");
    end
    #3 reset_n = 1'b1;
    idle(6, "after_reset");
    step(1, 4, 2, 0, "post_rst_wr");
    idle(6, "post_rst_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
